lcd_write_engine: RTL and testbench

- Physical-bus stage for the HD44780-compatible character LCD. It sits directly downstream of the text/LUT sequencer.
- Accepts one byte per request over an iStart/oDone handshake, then drives one timed write cycle on LCD_DATA/LCD_RS/LCD_EN.
- Waits the command-dependent execution time and holds off requests for the power-on delay after reset.
- The upstream sequencer therefore needs no delay counters of its own.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_delay_timer.sv | 46 ++++
 rtl/lcd_write_engine.sv | 110 +++++++++++
 tb/tb_lcd_write_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and default timing for the character-LCD write path
// Timing defaults assume a 50 MHz clock and are shared with the upstream sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    POR, IDLE, SETUP, EN_HI, HOLD, EXEC
  } lcdState_e;

  typedef enum logic [2:0] {
    TSEL_POR, TSEL_SETUP, TSEL_EN_HIGH, TSEL_HOLD, TSEL_EXEC_SHORT, TSEL_EXEC_LONG
  } timerSel_e;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFE;

  localparam int LCD_T_SETUP      = 3;
  localparam int LCD_T_EN_HIGH    = 16;
  localparam int LCD_T_HOLD       = 2;
  localparam int LCD_T_EXEC_SHORT = 2000;
  localparam int LCD_T_EXEC_LONG  = 82000;
  localparam int LCD_T_POR        = 750000;
  localparam int LCD_CNT_W        = 20;

  // Clear and return-home need the long execution wait; the home command ignores bit 0.
  function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) ||
                   ((data & LCD_CMD_HOME_MASK) == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - up-counter with selectable terminal count
// oExpired is combinational and lasts one cycle because the owner clears on every state change.
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = LCD_T_SETUP,
  parameter int T_EN_HIGH    = LCD_T_EN_HIGH,
  parameter int T_HOLD       = LCD_T_HOLD,
  parameter int T_EXEC_SHORT = LCD_T_EXEC_SHORT,
  parameter int T_EXEC_LONG  = LCD_T_EXEC_LONG,
  parameter int T_POR        = LCD_T_POR,
  parameter int CNT_W        = LCD_CNT_W
) (
  input  logic      iCLK,
  input  logic      iRST_N,
  input  logic      iClear,
  input  timerSel_e iSel,
  input  logic      iEnable,
  output logic      oExpired
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] target;

  always_comb begin
    target = CNT_W'(T_POR - 1);
    case (iSel)
      TSEL_POR:        target = CNT_W'(T_POR - 1);
      TSEL_SETUP:      target = CNT_W'(T_SETUP - 1);
      TSEL_EN_HIGH:    target = CNT_W'(T_EN_HIGH - 1);
      TSEL_HOLD:       target = CNT_W'(T_HOLD - 1);
      TSEL_EXEC_SHORT: target = CNT_W'(T_EXEC_SHORT - 1);
      TSEL_EXEC_LONG:  target = CNT_W'(T_EXEC_LONG - 1);
      default:         target = CNT_W'(T_POR - 1);
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)      count <= '0;
    else if (iClear)  count <= '0;
    else if (iEnable) count <= count + CNT_W'(1);
  end

  assign oExpired = iEnable && (count == target);

endmodule

// File: rtl/lcd_write_engine.sv
// rtl/lcd_write_engine.sv - timed HD44780 write cycle behind an iStart/oDone handshake
// Also enforces the power-on hold-off so the upstream sequencer needs no delay counters.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = LCD_T_SETUP,
  parameter int T_EN_HIGH    = LCD_T_EN_HIGH,
  parameter int T_HOLD       = LCD_T_HOLD,
  parameter int T_EXEC_SHORT = LCD_T_EXEC_SHORT,
  parameter int T_EXEC_LONG  = LCD_T_EXEC_LONG,
  parameter int T_POR        = LCD_T_POR,
  parameter int CNT_W        = LCD_CNT_W
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  lcdState_e state, stateNext;
  timerSel_e timerSel;
  logic      startQ, pending, longCmd;
  logic      rise, capture, expired;

  assign rise = iStart & ~startQ;

  lcd_delay_timer #(
    .T_SETUP(T_SETUP), .T_EN_HIGH(T_EN_HIGH), .T_HOLD(T_HOLD),
    .T_EXEC_SHORT(T_EXEC_SHORT), .T_EXEC_LONG(T_EXEC_LONG),
    .T_POR(T_POR), .CNT_W(CNT_W)
  ) uTimer (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iClear(stateNext != state), .iSel(timerSel),
    .iEnable(state != IDLE), .oExpired(expired)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= POR;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    timerSel  = TSEL_POR;
    case (state)
      POR:   if (expired) stateNext = IDLE;
      IDLE: begin
        timerSel = TSEL_SETUP;
        // A request held through POR is honoured only if iStart is still asserted.
        if (rise || (pending && iStart)) begin
          capture   = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        timerSel = TSEL_SETUP;
        if (expired) stateNext = EN_HI;
      end
      EN_HI: begin
        timerSel = TSEL_EN_HIGH;
        if (expired) stateNext = HOLD;
      end
      HOLD: begin
        timerSel = TSEL_HOLD;
        if (expired) stateNext = EXEC;
      end
      EXEC: begin
        timerSel = longCmd ? TSEL_EXEC_LONG : TSEL_EXEC_SHORT;
        if (expired) stateNext = IDLE;
      end
      default: stateNext = POR;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      startQ   <= 1'b0;
      pending  <= 1'b0;
      longCmd  <= 1'b0;
      oDone    <= 1'b0;
      oBusy    <= 1'b1;
      LCD_EN   <= 1'b0;
      LCD_DATA <= 8'h00;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
    end else begin
      startQ <= iStart;
      oDone  <= (state == EXEC) && expired;
      oBusy  <= (stateNext != IDLE);
      LCD_EN <= (stateNext == EN_HI);
      LCD_RW <= 1'b0;
      if (state == POR && rise) pending <= 1'b1;
      else if (state == IDLE)   pending <= 1'b0;
      if (capture) begin
        LCD_DATA <= iDATA;
        LCD_RS   <= iRS;
        longCmd  <= isLongCmd(iRS, iDATA);
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb/tb_lcd_write_engine.sv - randomized scoreboard bench for lcd_write_engine
// Stimulus queues expected bus cycles; a negedge monitor checks strobe timing, data and oDone.
module tb_lcd_write_engine;

  localparam int TS = 2, TE = 4, TH = 2, TXS = 10, TXL = 50, TP = 20;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic       iRS = 1'b0;
  logic       iStart = 1'b0;
  logic       oDone, oBusy, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  lcd_write_engine #(
    .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH),
    .T_EXEC_SHORT(TXS), .T_EXEC_LONG(TXL), .T_POR(TP), .CNT_W(20)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(oDone), .oBusy(oBusy), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         enRise;
    int         doneAt;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0, nFails = 0;
  logic enPrev = 1'b0;
  int   enStart = 0;
  int   relCyc = 0;

  task automatic check(input string name, input int act, input int req);
    nChecks++;
    if (act != req) begin
      nFails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference rule: clear and home commands (0x01..0x03 on the instruction register) wait long.
  function automatic int refLatency(input logic rs, input logic [7:0] d);
    int execT;
    execT = (!rs && (d inside {8'h01, 8'h02, 8'h03})) ? TXL : TXS;
    return TS + TE + TH + execT;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic expect_write(input logic [7:0] d, input logic rs, input int capEdge);
    exp_t e;
    e.data   = d;
    e.rs     = rs;
    e.enRise = capEdge + TS;
    e.doneAt = capEdge + refLatency(rs, d);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [7:0] d, input logic rs);
    iDATA  = d;
    iRS    = rs;
    iStart = 1'b1;
    expect_write(d, rs, cyc + 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!oDone && n < budget) begin
      tick();
      n++;
    end
    if (!oDone) check("done_timeout", 0, 1);
  endtask

  initial begin
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        enPrev = 1'b0;
      end else begin
        if (LCD_EN && !enPrev) begin
          if (sb.size() == 0) check("unexpected_en", 1, 0);
          else begin
            check("en_rise_cycle", cyc, sb[0].enRise);
            check("lcd_data", int'(LCD_DATA), int'(sb[0].data));
            check("lcd_rs", int'(LCD_RS), int'(sb[0].rs));
            check("lcd_rw", int'(LCD_RW), 0);
          end
          enStart = cyc;
        end
        if (!LCD_EN && enPrev) begin
          check("en_width", cyc - enStart, TE);
          if (sb.size() > 0) check("hold_data", int'(LCD_DATA), int'(sb[0].data));
        end
        if (oDone) begin
          if (sb.size() == 0) check("unexpected_done", 1, 0);
          else begin
            check("done_cycle", cyc, sb[0].doneAt);
            check("idle_at_done", int'(oBusy), 0);
            void'(sb.pop_front());
          end
        end
        enPrev = LCD_EN;
      end
    end
  end

  initial begin
    logic [7:0] dirData [5];
    logic       dirRs   [5];
    logic [7:0] d;
    logic       rs;
    logic       glitch;
    int         n;
    dirData = '{8'h41, 8'h01, 8'h03, 8'h01, 8'h02};
    dirRs   = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

    tick();
    tick();
    check("rst_busy", int'(oBusy), 1);
    check("rst_en", int'(LCD_EN), 0);
    check("rst_data", int'(LCD_DATA), 0);
    check("rst_rs", int'(LCD_RS), 0);
    check("rst_rw", int'(LCD_RW), 0);
    check("rst_done", int'(oDone), 0);

    // Power-on hold-off: request raised during POR and held.
    iRST_N = 1'b1;
    relCyc = cyc;
    repeat (5) tick();
    iDATA  = 8'h38;
    iRS    = 1'b0;
    iStart = 1'b1;
    expect_write(8'h38, 1'b0, relCyc + TP + 1);
    while (cyc < relCyc + TP - 1) tick();
    check("por_busy", int'(oBusy), 1);
    tick();
    check("por_idle", int'(oBusy), 0);
    wait_done(200);
    repeat (10) tick();

    for (int i = 0; i < 17; i++) begin
      if (i < 5) begin
        d      = dirData[i];
        rs     = dirRs[i];
        glitch = (i == 0);
      end else begin
        d      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
        rs     = 1'($urandom_range(0, 1));
        glitch = ($urandom_range(0, 2) == 0);
      end
      iStart = 1'b0;
      tick();
      issue(d, rs);
      if (glitch) begin
        repeat (TS + TE + TH + 3) tick();
        iStart = 1'b0;
        tick();
        iStart = 1'b1;
      end
      wait_done(200);
    end

    // Reset while the enable strobe is high.
    iStart = 1'b0;
    tick();
    issue(8'h55, 1'b1);
    n = 0;
    while (!LCD_EN && n < 20) begin
      tick();
      n++;
    end
    check("en_reached", int'(LCD_EN), 1);
    #2;
    iRST_N = 1'b0;
    sb.delete();
    #1;
    check("async_en", int'(LCD_EN), 0);
    check("async_data", int'(LCD_DATA), 0);
    check("async_busy", int'(oBusy), 1);
    iStart = 1'b0;
    tick();
    tick();
    iRST_N = 1'b1;
    relCyc = cyc;
    // A request that rises and falls inside POR must be discarded.
    repeat (3) tick();
    iDATA  = 8'h77;
    iStart = 1'b1;
    repeat (5) tick();
    iStart = 1'b0;
    while (cyc < relCyc + TP - 1) tick();
    check("por2_busy", int'(oBusy), 1);
    while (cyc < relCyc + 2 * TP) tick();
    check("por2_idle", int'(oBusy), 0);
    check("por2_no_en", int'(LCD_EN), 0);

    issue(8'h01, 1'b0);
    wait_done(200);
    iStart = 1'b0;
    repeat (5) tick();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
